spi_regif: RTL and testbench
============================

Name: spi_regif

Overview:
- Downstream consumer of the SPI front end.
- Takes each completed SPI frame (parallel rx word, qualified by the slave-select rising-edge strobe) and decodes it into a register-bus read or write command.
- Issues the command on a valid/ready bus and returns read data through the parallel tx word the front end shifts out on the next frame.
- Sits between the SPI front end and the peripheral register bank.

Parameters:
- DATA_W, 32: SPI frame width; must match the front end.
- ADDR_W, 7: register address width.
- PAY_W, DATA_W-1-ADDR_W (24): payload/bus data width; derived, not overridable.
- TIMEOUT, 255: maximum clk cycles to wait for a read response; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- ss_pos_edge  in  1  frame-end strobe from front end, one cycle wide
- ss_neg_edge  in  1  frame-start strobe from front end, one cycle wide
- rx_data  in  DATA_W  received frame from front end
- tx_data  out  DATA_W  word for front end to transmit on the next frame
- req_valid  out  1  bus request valid
- req_ready  in  1  bus request accepted
- req_write  out  1  1=write, 0=read
- req_addr  out  ADDR_W  register address
- req_wdata  out  PAY_W  write data
- rsp_valid  in  1  read data valid, one cycle wide
- rsp_rdata  in  PAY_W  read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all outputs 0; tx_data=0; sticky flags=0; timeout counter=0.
- Frame format: rx_data[DATA_W-1]=write flag; [DATA_W-2:PAY_W]=addr; [PAY_W-1:0]=wdata.
- tx_data format:
  - [DATA_W-1] resp_valid
  - [DATA_W-2] overrun
  - [DATA_W-3] error (timeout or parity)
  - [DATA_W-4:PAY_W] zero
  - [PAY_W-1:0] last read data
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE:
  - On ss_pos_edge, register addr/wdata/write flag; req_valid=1 from the next cycle; go to REQ.
  - Latency: 1 cycle from strobe to req_valid.
- REQ:
  - req_valid and all req_* held stable until the cycle req_ready=1.
  - On acceptance of a write: go to IDLE.
  - On acceptance of a read: clear timeout counter, go to WAIT_RSP.
  - req_valid deasserts the cycle after acceptance.
- WAIT_RSP:
  - On rsp_valid: tx_data[PAY_W-1:0]=rsp_rdata, resp_valid=1, go to IDLE.
  - Counter increments every cycle; when it reaches TIMEOUT with no rsp_valid: set error, read data=0, go to IDLE.
  - rsp_valid outside WAIT_RSP is ignored.
- Overrun: ss_pos_edge while FSM not IDLE → frame dropped, overrun=1; the in-flight transaction completes normally.
- Flag clear:
  - ss_neg_edge clears resp_valid, overrun and error (the tx word was consumed at frame start); read data bits retained.
  - If rsp_valid and ss_neg_edge coincide: clear first, then the response is captured; resp_valid=1 after that cycle.
  - If an overrun/error set and ss_neg_edge coincide: set wins.
- ss_pos_edge and ss_neg_edge in the same cycle: illegal from the front end; ss_pos_edge is processed, ss_neg_edge ignored.
- Reset mid-transaction: immediate abort, no bus handshake completion required; the bus side must tolerate req_valid dropping.

Optional Feature:
- Macro: SPI_REGIF_PARITY_EN.
- Defined:
  - rx_data[0] is an even-parity bit over rx_data[DATA_W-1:1].
  - wdata = {rx_data[PAY_W-1:1], 1'b0} (bit 0 reserved).
  - On mismatch: frame dropped, error=1, FSM stays IDLE.
  - tx_data[0] is driven so the whole tx word has even parity (overrides rdata bit 0).
- Not defined: no parity logic; all PAY_W bits are data; error flags timeout only.

Decomposition:
- Shared package spi_regif_pkg holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT_RSP=2'd2)
  - tx flag bit-index constants
  - PAY_W derivation
- DATA_W stays in the existing shared SPI defines.
- One natural sub-module: spi_regif_timeout (load/enable/expire counter).
- Frame decode and the FSM stay in the top.

Test Plan:
- Write: rx_data=0x8A_123456, ss_pos_edge, req_ready=1 after 2 cycles → req_write=1, addr=0x0A, wdata=0x123456 held 3 cycles; FSM IDLE after acceptance; tx_data unchanged.
- Read: rx_data=0x05_000000, accept immediately, rsp_valid with 0xABCDEF 4 cycles later → tx_data=0x80ABCDEF; next ss_neg_edge → tx_data=0x00ABCDEF.
- Timeout: TIMEOUT=8, read accepted, no rsp_valid → after 8 cycles tx_data=0x20000000, busy=0.
- Overrun: second ss_pos_edge while req_ready=0 → only the first command issued; tx_data[30]=1 until next ss_neg_edge.
- Coincidence: rsp_valid and ss_neg_edge same cycle → resp_valid=1 afterwards; async reset asserted in REQ → all outputs 0 immediately.
- Parity (macro defined): frame with odd parity → no req_valid, tx_data[29]=1; valid frame → tx word has even parity.

Source files
------------

// File: rtl/spi_regif_pkg.sv
// spi_regif_pkg: shared constants for the SPI register interface.
// Holds the FSM state encoding, the tx status flag positions (as offsets
// from the MSB of the frame) and the payload width derivation.
package spi_regif_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_REQ      = 2'd1;
  localparam state_t ST_WAIT_RSP = 2'd2;

  // Flag bit index = DATA_W - offset
  localparam int TX_RESP_VALID_OFS = 1;
  localparam int TX_OVERRUN_OFS    = 2;
  localparam int TX_ERROR_OFS      = 3;

  // Payload carries whatever is left after the write flag and the address
  function automatic int calc_pay_w(input int data_w, input int addr_w);
    return data_w - 1 - addr_w;
  endfunction

endpackage

// File: rtl/spi_regif_timeout.sv
// spi_regif_timeout: read-response watchdog.
// load clears the count, en advances it once per cycle, and expire marks the
// waiting cycle in which the count reaches TIMEOUT (TIMEOUT must be >= 1).
module spi_regif_timeout #(
  parameter  int TIMEOUT = 255,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Count waiting cycles; hold at TIMEOUT so the counter never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(TIMEOUT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/spi_regif.sv
// spi_regif: decodes completed SPI frames into register-bus commands and
// returns status plus read data through the tx word of the next frame.
// Optional feature macro: SPI_REGIF_PARITY_EN (even parity in rx_data[0],
// parity-corrected tx word). Default build has no parity logic.
module spi_regif
  import spi_regif_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 7,
  parameter  int TIMEOUT = 255,
  localparam int PAY_W   = calc_pay_w(DATA_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_pos_edge,
  input  logic              ss_neg_edge,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [PAY_W-1:0]  req_wdata,
  input  logic              rsp_valid,
  input  logic [PAY_W-1:0]  rsp_rdata,
  output logic              busy
);

  state_t            state;
  logic              resp_flag;
  logic              ovr_flag;
  logic              err_flag;
  logic [PAY_W-1:0]  rdata;

  logic              frm_write;
  logic [ADDR_W-1:0] frm_addr;
  logic [PAY_W-1:0]  frm_wdata;
  logic              frm_ok;
  logic              acc_read;
  logic              tmo_expire;
  logic [DATA_W-1:0] tx_word;

  // Frame fields
  assign frm_write = rx_data[DATA_W-1];
  assign frm_addr  = rx_data[DATA_W-2:PAY_W];

`ifdef SPI_REGIF_PARITY_EN
  function automatic logic xor_all(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  // Bit 0 is the parity bit, so it never reaches the bus
  assign frm_wdata = {rx_data[PAY_W-1:1], 1'b0};
  assign frm_ok    = ~xor_all(rx_data);
`else
  assign frm_wdata = rx_data[PAY_W-1:0];
  assign frm_ok    = 1'b1;
`endif

  // A read accepted this cycle restarts the response watchdog
  assign acc_read = (state == ST_REQ) && req_ready && !req_write;

  spi_regif_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (acc_read),
    .en     (state == ST_WAIT_RSP),
    .expire (tmo_expire)
  );

  // Command FSM and sticky status; later assignments win, so flag sets and
  // response capture override the frame-start clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      resp_flag <= 1'b0;
      ovr_flag  <= 1'b0;
      err_flag  <= 1'b0;
      rdata     <= '0;
    end else begin
      // Frame start consumed the tx word; both strobes at once is treated
      // as a frame end only
      if (ss_neg_edge && !ss_pos_edge) begin
        resp_flag <= 1'b0;
        ovr_flag  <= 1'b0;
        err_flag  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (ss_pos_edge) begin
            if (frm_ok) begin
              req_write <= frm_write;
              req_addr  <= frm_addr;
              req_wdata <= frm_wdata;
              req_valid <= 1'b1;
              state     <= ST_REQ;
            end else begin
              err_flag  <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          if (ss_pos_edge) begin
            ovr_flag <= 1'b1;
          end
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= req_write ? ST_IDLE : ST_WAIT_RSP;
          end
        end

        ST_WAIT_RSP: begin
          if (ss_pos_edge) begin
            ovr_flag <= 1'b1;
          end
          if (rsp_valid) begin
            rdata     <= rsp_rdata;
            resp_flag <= 1'b1;
            state     <= ST_IDLE;
          end else if (tmo_expire) begin
            rdata     <= '0;
            err_flag  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          req_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Assemble the status/read-data word for the next frame
  always_comb begin
    tx_word                            = '0;
    tx_word[DATA_W-TX_RESP_VALID_OFS]  = resp_flag;
    tx_word[DATA_W-TX_OVERRUN_OFS]     = ovr_flag;
    tx_word[DATA_W-TX_ERROR_OFS]       = err_flag;
    tx_word[PAY_W-1:0]                 = rdata;
`ifdef SPI_REGIF_PARITY_EN
    tx_word[0]                         = ^tx_word[DATA_W-1:1];
`endif
  end

  assign tx_data = tx_word;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_regif.sv
// tb_spi_regif: directed bench for spi_regif with a bus-request scoreboard.
module tb_spi_regif;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 7;
  localparam int PAY_W   = 24;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ss_pos_edge = 1'b0;
  logic              ss_neg_edge = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic [DATA_W-1:0] tx_data;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [PAY_W-1:0]  req_wdata;
  logic              rsp_valid = 1'b0;
  logic [PAY_W-1:0]  rsp_rdata = '0;
  logic              busy;

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [PAY_W-1:0]  d;
  } req_t;

  req_t sb[$];
  int   total = 0;
  int   bad   = 0;

  spi_regif #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ss_pos_edge (ss_pos_edge),
    .ss_neg_edge (ss_neg_edge),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame with its parity bit fixed up when parity is enabled
  function automatic logic [31:0] mk(input logic [31:0] f);
`ifdef SPI_REGIF_PARITY_EN
    f[0] = ^f[31:1];
`endif
    return f;
  endfunction

  function automatic logic [31:0] exp_tx(input logic [31:0] v);
`ifdef SPI_REGIF_PARITY_EN
    v[0] = ^v[31:1];
`endif
    return v;
  endfunction

  function automatic logic [PAY_W-1:0] exp_wd(input logic [31:0] f);
    logic [PAY_W-1:0] d;
    d = f[PAY_W-1:0];
`ifdef SPI_REGIF_PARITY_EN
    d[0] = 1'b0;
`endif
    return d;
  endfunction

  task automatic push(input logic [31:0] f);
    req_t e;
    e.w = f[31];
    e.a = f[30:24];
    e.d = exp_wd(f);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pos(input logic [31:0] f);
    rx_data     = f;
    ss_pos_edge = 1'b1;
    tick();
    ss_pos_edge = 1'b0;
  endtask

  task automatic pulse_neg();
    ss_neg_edge = 1'b1;
    tick();
    ss_neg_edge = 1'b0;
  endtask

  // Every accepted request must match the oldest expected command
  always @(negedge clk) begin
    if (rst && req_valid && req_ready) begin
      chk("sb_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        req_t e;
        e = sb.pop_front();
        chk("bus_write", req_write, e.w);
        chk("bus_addr",  req_addr,  e.a);
        chk("bus_wdata", req_wdata, e.d);
      end
    end
  end

  initial begin
    logic [31:0] f;

    // Reset state
    tick();
    tick();
    chk("rst_tx",     tx_data,   0);
    chk("rst_valid",  req_valid, 0);
    chk("rst_busy",   busy,      0);
    chk("rst_write",  req_write, 0);
    chk("rst_addr",   req_addr,  0);
    chk("rst_wdata",  req_wdata, 0);
    rst = 1'b1;
    tick();

    // Write, accepted after being held three cycles
    f = mk(32'h8A12_3456);
    push(f);
    pulse_pos(f);
    chk("wr_valid",  req_valid, 1);
    chk("wr_busy",   busy,      1);
    chk("wr_write",  req_write, 1);
    chk("wr_addr",   req_addr,  7'h0A);
    chk("wr_wdata",  req_wdata, exp_wd(f));
    tick();
    chk("wr_hold1",  {req_valid, req_addr}, {1'b1, 7'h0A});
    tick();
    chk("wr_hold2",  req_wdata, exp_wd(f));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("wr_drop",   req_valid, 0);
    chk("wr_idle",   busy,      0);
    chk("wr_tx",     tx_data,   exp_tx(32'h0));

    // Read, accepted immediately, response four cycles later
    f = mk(32'h0500_0000);
    push(f);
    req_ready = 1'b1;
    pulse_pos(f);
    chk("rd_valid",  req_valid, 1);
    tick();
    req_ready = 1'b0;
    chk("rd_wait",   {busy, req_valid}, 2'b10);
    tick();
    tick();
    tick();
    rsp_valid = 1'b1;
    rsp_rdata = 24'hABCDEF;
    tick();
    rsp_valid = 1'b0;
    chk("rd_tx",     tx_data, exp_tx(32'h80AB_CDEF));
    chk("rd_idle",   busy,    0);
    pulse_neg();
    chk("rd_clear",  tx_data, exp_tx(32'h00AB_CDEF));

    // Response strobe while idle is ignored
    rsp_valid = 1'b1;
    rsp_rdata = 24'h555555;
    tick();
    rsp_valid = 1'b0;
    chk("rsp_ignored", tx_data, exp_tx(32'h00AB_CDEF));

    // Timeout, with a frame start landing on the expiry cycle
    f = mk(32'h0700_0000);
    push(f);
    req_ready = 1'b1;
    pulse_pos(f);
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("tmo_busy",  busy, 1);
    ss_neg_edge = 1'b1;
    tick();
    ss_neg_edge = 1'b0;
    chk("tmo_idle",  busy,    0);
    chk("tmo_tx",    tx_data, exp_tx(32'h2000_0000));
    pulse_neg();
    chk("tmo_clear", tx_data, exp_tx(32'h0));

    // Overrun: second frame while the first is still pending
    f = mk(32'h8100_0111);
    push(f);
    pulse_pos(f);
    tick();
    pulse_pos(mk(32'h8200_0222));
    chk("ovr_tx",    tx_data,  exp_tx(32'h4000_0000));
    chk("ovr_addr",  req_addr, 7'h01);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    tick();
    chk("ovr_idle",  busy,    0);
    chk("ovr_keep",  tx_data, exp_tx(32'h4000_0000));
    pulse_neg();
    chk("ovr_clear", tx_data, exp_tx(32'h0));

    // Response and frame start in the same cycle
    f = mk(32'h0900_0000);
    push(f);
    req_ready = 1'b1;
    pulse_pos(f);
    tick();
    req_ready = 1'b0;
    tick();
    rsp_valid   = 1'b1;
    rsp_rdata   = 24'h13579B;
    ss_neg_edge = 1'b1;
    tick();
    rsp_valid   = 1'b0;
    ss_neg_edge = 1'b0;
    chk("coin_tx",   tx_data, exp_tx(32'h8013_579B));

    // Both strobes together: frame end processed, frame start ignored
    f = mk(32'h8300_0333);
    push(f);
    pulse_pos(f);
    rx_data     = mk(32'h8400_0444);
    ss_pos_edge = 1'b1;
    ss_neg_edge = 1'b1;
    tick();
    ss_pos_edge = 1'b0;
    ss_neg_edge = 1'b0;
    chk("both_tx",   tx_data,  exp_tx(32'hC013_579B));
    chk("both_addr", req_addr, 7'h03);

    // Asynchronous reset while a request is pending
    rst = 1'b0;
    #1;
    chk("arst_valid", req_valid, 0);
    chk("arst_busy",  busy,      0);
    chk("arst_tx",    tx_data,   0);
    chk("arst_addr",  req_addr,  0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();

`ifdef SPI_REGIF_PARITY_EN
    // Bad parity frame is dropped
    pulse_pos(mk(32'h8A12_3456) ^ 32'h1);
    chk("par_novalid", {req_valid, busy}, 2'b00);
    chk("par_err",     tx_data[29], 1);
    pulse_neg();
    // Good frame: read back and check tx parity
    f = mk(32'h0600_0000);
    push(f);
    req_ready = 1'b1;
    pulse_pos(f);
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 24'hABCDEF;
    tick();
    rsp_valid = 1'b0;
    chk("par_even",    ^tx_data, 0);
    chk("par_tx",      tx_data,  exp_tx(32'h80AB_CDEF));
`endif

    tick();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
